// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - instruction ROM with combinational fetch and byte-serial run-time loader
// Optional word checksum on checksum_o when INST_MEM_CHECKSUM_EN is defined.
module inst_mem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rom_ce_i,
  input  logic [31:0]           rom_addr_i,
  output logic [31:0]           rom_data_o,
  input  logic                  load_start_i,
  input  logic                  load_valid_i,
  input  logic [7:0]            load_byte_i,
  output logic                  load_ready_o,
  input  logic                  load_end_i,
  output logic                  load_busy_o,
  output logic                  load_ovf_o,
  output logic [ADDR_WIDTH:0]   load_count_o,
  output logic [31:0]           checksum_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_COMMIT} state_t;

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [31:0]         r_shift;
  logic                r_pend;
  logic [ADDR_WIDTH:0] r_ptr;
  logic                r_ready;
  logic                r_busy;
  logic                r_ovf;
  logic [31:0]         r_mem [DEPTH];

  logic                w_acc;
  logic [2:0]          w_cnt_n;
  logic [31:0]         w_shift_n;
  logic [31:0]         w_pad;
  logic                w_room;
  logic                w_we;
  logic                w_unused_addr;

  assign w_acc     = (r_state == S_RECV) && load_valid_i;
  assign w_cnt_n   = r_cnt + {2'b00, w_acc};
  assign w_shift_n = w_acc ? {r_shift[23:0], load_byte_i} : r_shift;
  // Pointer saturates at DEPTH, so its top bit alone means "array full".
  assign w_room    = ~r_ptr[ADDR_WIDTH];
  assign w_we      = (r_state == S_COMMIT) && !load_start_i && w_room;

  // Left-align a short final word so the first byte lands in bits [31:24].
  always_comb begin
    w_pad = w_shift_n;
    case (w_cnt_n)
      3'd1:    w_pad = {w_shift_n[7:0], 24'h0};
      3'd2:    w_pad = {w_shift_n[15:0], 16'h0};
      3'd3:    w_pad = {w_shift_n[23:0], 8'h0};
      default: w_pad = w_shift_n;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 32'h0;
      r_pend  <= 1'b0;
      r_ptr   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (load_start_i) begin
      r_state <= S_RECV;
      r_cnt   <= 3'd0;
      r_shift <= 32'h0;
      r_pend  <= 1'b0;
      r_ptr   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_RECV: begin
          if (w_cnt_n == 3'd4) begin
            r_state <= S_COMMIT;
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
            r_pend  <= load_end_i;
            r_ready <= 1'b0;
          end else if (load_end_i) begin
            r_ready <= 1'b0;
            if (w_cnt_n == 3'd0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_COMMIT;
              r_shift <= w_pad;
              r_cnt   <= w_cnt_n;
              r_pend  <= 1'b1;
            end
          end else begin
            r_shift <= w_shift_n;
            r_cnt   <= w_cnt_n;
          end
        end
        S_COMMIT: begin
          if (w_room) r_ptr <= r_ptr + 1'b1;
          else        r_ovf <= 1'b1;
          r_cnt   <= 3'd0;
          r_shift <= 32'h0;
          r_pend  <= 1'b0;
          if (r_pend || load_end_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
          end else begin
            r_state <= S_RECV;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_ptr[ADDR_WIDTH-1:0]] <= r_shift;
  end

`ifdef INST_MEM_CHECKSUM_EN
  logic [31:0] r_sum;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_sum <= 32'h0;
    else if (load_start_i) r_sum <= 32'h0;
    else if (w_we)         r_sum <= r_sum + r_shift;
  end
  assign checksum_o = r_sum;
`else
  assign checksum_o = 32'h0;
`endif

  assign rom_data_o    = (rom_ce_i && !r_busy) ? r_mem[rom_addr_i[ADDR_WIDTH+1:2]] : NOP_WORD;
  assign w_unused_addr = ^{rom_addr_i[31:ADDR_WIDTH+2], rom_addr_i[1:0]};

  assign load_ready_o  = r_ready;
  assign load_busy_o   = r_busy;
  assign load_ovf_o    = r_ovf;
  assign load_count_o  = r_ptr;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - self-checking bench for inst_mem_loader (depth 1024 and depth 4 instances)
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] addr1, addr2, data1, data2;
  logic        start, valid, endp;
  logic [7:0]  byte_i;
  logic        ready1, ready2, busy1, busy2, ovf1, ovf2;
  logic [10:0] cnt1;
  logic [2:0]  cnt2;
  logic [31:0] sum1, sum2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  q[$];
  logic [31:0] m1[1024];
  bit          v1[1024];
  logic [31:0] m2[4];
  bit          v2[4];
  int          exp_words = 0;
  logic [31:0] exp_sum1 = 0, exp_sum2 = 0;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_WIDTH(10)) dut1 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(addr1), .rom_data_o(data1),
    .load_start_i(start), .load_valid_i(valid), .load_byte_i(byte_i), .load_ready_o(ready1),
    .load_end_i(endp), .load_busy_o(busy1), .load_ovf_o(ovf1), .load_count_o(cnt1),
    .checksum_o(sum1));

  inst_mem_loader #(.ADDR_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(addr2), .rom_data_o(data2),
    .load_start_i(start), .load_valid_i(valid), .load_byte_i(byte_i), .load_ready_o(ready2),
    .load_end_i(endp), .load_busy_o(busy2), .load_ovf_o(ovf2), .load_count_o(cnt2),
    .checksum_o(sum2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a session's bytes become big-endian words, last one zero-padded,
  // kept only while they fit in the array.
  task automatic model_flush(input bit pad);
    int n, nw;
    logic [31:0] w;
    n  = q.size();
    nw = pad ? (n + 3) / 4 : n / 4;
    exp_words = nw;
    exp_sum1  = 0;
    exp_sum2  = 0;
    for (int i = 0; i < nw; i++) begin
      w = 0;
      for (int k = 0; k < 4; k++) w = {w[23:0], (4*i+k < n) ? q[4*i+k] : 8'h00};
      if (i < 1024) begin m1[i] = w; v1[i] = 1; exp_sum1 += w; end
      if (i < 4)    begin m2[i] = w; v2[i] = 1; exp_sum2 += w; end
    end
    q.delete();
  endtask

  task automatic do_start();
    @(negedge clk); start = 1;
    @(posedge clk); #1 start = 0;
    model_flush(0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    int t;
    @(negedge clk); valid = 1; byte_i = b;
    t = 0;
    while (!ready1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("ready_timeout", 1, 0);
    endp = with_end;
    @(posedge clk); #1 valid = 0; endp = 0;
    q.push_back(b);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy1 && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) chk("idle_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic end_session();
    @(negedge clk); endp = 1;
    @(posedge clk); #1 endp = 0;
    wait_idle();
    model_flush(1);
  endtask

  task automatic check_session(input string tag);
    int ew1, ew2;
    ew1 = (exp_words > 1024) ? 1024 : exp_words;
    ew2 = (exp_words > 4) ? 4 : exp_words;
    chk({tag, ".busy"}, busy1, 0);
    chk({tag, ".ready"}, ready1, 0);
    chk({tag, ".cnt1"}, cnt1, ew1);
    chk({tag, ".cnt2"}, cnt2, ew2);
    chk({tag, ".ovf1"}, ovf1, exp_words > 1024);
    chk({tag, ".ovf2"}, ovf2, exp_words > 4);
`ifdef INST_MEM_CHECKSUM_EN
    chk({tag, ".sum1"}, sum1, exp_sum1);
    chk({tag, ".sum2"}, sum2, exp_sum2);
`else
    chk({tag, ".sum1"}, sum1, 0);
    chk({tag, ".sum2"}, sum2, 0);
`endif
    rom_ce = 1;
    for (int i = 0; i < 16; i++) begin
      addr1 = ($urandom() & 32'hFFFF_F000) | (i << 2) | $urandom_range(0, 3);
      addr2 = ($urandom() & 32'hFFFF_FFF0) | ((i % 4) << 2) | $urandom_range(0, 3);
      #1;
      if (v1[i]) chk({tag, ".fetch1"}, data1, m1[i]);
      if (i < 4 && v2[i]) chk({tag, ".fetch2"}, data2, m2[i]);
    end
    rom_ce = 0;
  endtask

  initial begin
    int n;
    rst = 0; rom_ce = 0; addr1 = 0; addr2 = 0;
    start = 0; valid = 0; endp = 0; byte_i = 0;
    repeat (3) @(negedge clk);
    chk("rst.ready", ready1, 0);
    chk("rst.busy", busy1, 0);
    chk("rst.ovf", ovf1, 0);
    chk("rst.cnt", cnt1, 0);
    chk("rst.sum", sum1, 0);
    chk("rst.nop_ce0", data1, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("post_rst.busy", busy1, 0);
    chk("post_rst.ready", ready1, 0);

    // Basic two-word load, NOP fetch while busy
    do_start();
    rom_ce = 1; addr1 = 0; #1;
    chk("busy_nop", data1, 32'h0);
    chk("busy_flag", busy1, 1);
    rom_ce = 0;
    foreach (q[i]) ;
    send_byte(8'h24, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    send_byte(8'h34, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    end_session();
    check_session("two_words");
    rom_ce = 1; addr1 = 32'd4; #1;
    chk("fetch_addr4", data1, 32'h34030007);
    rom_ce = 0;

    // Partial word with end on the same cycle as the last byte
    do_start();
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 1);
    wait_idle();
    model_flush(1);
    check_session("partial");
    rom_ce = 1; addr1 = 0; #1;
    chk("partial_word", data1, 32'hAABBCC00);
    rom_ce = 0;

    // Five words: depth-4 instance overflows and wraps
    do_start();
    for (int i = 0; i < 20; i++) send_byte(8'($urandom()), 0);
    end_session();
    check_session("overflow");
    rom_ce = 1; addr2 = 32'd16; #1;
    chk("wrap16", data2, m2[0]);
    rom_ce = 0;

    // Checksum wrap-around
    do_start();
    for (int i = 0; i < 4; i++) send_byte(8'hFF, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h02, 0);
    end_session();
    check_session("checksum");
`ifdef INST_MEM_CHECKSUM_EN
    chk("checksum_const", sum1, 32'h00000001);
`else
    chk("checksum_const", sum1, 32'h00000000);
`endif

    // Restart mid-session discards the partial word
    do_start();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom()), 0);
    do_start();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom()), 0);
    end_session();
    check_session("restart");

    // Reset mid-session: partial lost, committed words kept
    do_start();
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    @(negedge clk); rst = 0; #1;
    q.delete();
    exp_words = 0; exp_sum1 = 0; exp_sum2 = 0;
    chk("midrst.busy", busy1, 0);
    chk("midrst.ready", ready1, 0);
    @(negedge clk); rst = 1;
    @(negedge clk);
    check_session("midrst");

    // Randomized sessions
    for (int s = 0; s < 5; s++) begin
      do_start();
      n = $urandom_range(0, 23);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(8'($urandom()), (i == n - 1) && ($urandom_range(0, 1) == 1));
      end
      if (!busy1) begin
        @(negedge clk);
        model_flush(1);
      end else begin
        end_session();
      end
      check_session("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
